aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The module SHALL have a parameter NR, default 10, giving the AES-128 round count; only 10 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port load, input, 1 bit: start request, sampled in IDLE or DONE.
REQ-005 The module SHALL have port abort, input, 1 bit: synchronous cancel; returns the controller to IDLE.
REQ-006 The module SHALL have port busy, output, 1 bit: high in INIT, SUB or UPD.
REQ-007 The module SHALL have port done, output, 1 bit: high in DONE only.
REQ-008 The module SHALL have port round, output, 4 bits: current round index, 0..10.
REQ-009 The module SHALL have port phase, output, 1 bit: 0 = S-box read cycle (SUB), 1 = combine cycle (INIT/UPD).
REQ-010 The module SHALL have port sel_init, output, 1 bit: datapath selects the plaintext and cipher-key path (state <= pt ^ key).
REQ-011 The module SHALL have port sel_last, output, 1 bit: bypass mixColumns (final round).
REQ-012 The module SHALL have port state_en, output, 1 bit: load enable for the datapath state register.
REQ-013 The module SHALL have port key_en, output, 1 bit: load enable for the round-key register.
REQ-014 The module SHALL have port rcon, output, 8 bits: round constant for key expansion.

Function
REQ-015 The controller SHALL be a Moore FSM with states IDLE, INIT, SUB, UPD and DONE; all outputs SHALL be decoded from registered state, round and rcon only.
REQ-016 IDLE SHALL go to INIT on load=1 and SHALL otherwise stay in IDLE.
REQ-017 INIT SHALL go to SUB with round <= 1 and rcon register <= 8'h01.
REQ-018 SUB SHALL always go to UPD, allowing one cycle of synchronous S-box latency.
REQ-019 UPD SHALL go to DONE when round==NR.
REQ-020 Otherwise, UPD SHALL go to SUB with round <= round+1 and rcon register <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
REQ-021 DONE SHALL go to INIT on load=1, restarting the sequence, and SHALL otherwise hold in DONE.
REQ-022 abort=1 SHALL force IDLE on the next edge from any state, with round <= 0; abort SHALL take priority over load.
REQ-023 load SHALL be ignored in INIT, SUB and UPD; an active operation SHALL not be restarted.
REQ-024 In INIT: state_en=1, key_en=1, sel_init=1, phase=1, round=0.
REQ-025 In SUB: state_en=0, key_en=0, phase=0.
REQ-026 In UPD: state_en=1, key_en=1, phase=1.
REQ-027 sel_last SHALL be 1 only in SUB or UPD with round==NR.
REQ-028 rcon SHALL output the rcon register in SUB and UPD, and 8'h00 in IDLE, INIT and DONE.
REQ-029 The rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-030 Latency SHALL be as follows: with load sampled high at edge 0, INIT occupies cycle 1, round r SUB occupies cycle 2r, round r UPD occupies cycle 2r+1, and done rises in cycle 22.
REQ-031 Exactly 11 state_en pulses SHALL occur per completed operation.
REQ-032 done SHALL fall on the edge that leaves DONE, either by load or by abort.
REQ-033 round SHALL never exceed NR, and the counter SHALL not wrap.

Reset
REQ-034 reset=1 SHALL immediately, asynchronously, force IDLE, round=0 and rcon register=8'h00.
REQ-035 During reset: all outputs 0 (busy, done, phase, sel_init, sel_last, state_en, key_en, rcon).
REQ-036 Reset asserted mid-operation SHALL abandon the operation without a done pulse.
REQ-037 After reset release, the controller SHALL wait in IDLE for a new load.

Verification
REQ-038 Nominal: load pulse at edge 0 -> INIT in cycle 1; state_en high in cycles 1,3,5,...,21 (11 pulses); done=1 from cycle 22; round=10 and sel_last=1 in cycles 20-21.
REQ-039 rcon trace: sample rcon in each UPD -> 01,02,04,08,10,20,40,80,1B,36; rcon=00 in IDLE, INIT and DONE.
REQ-040 load held high for 30 cycles from IDLE -> exactly one operation, done at cycle 22; the held load in DONE then restarts INIT at cycle 23.
REQ-041 abort in cycle 9 (round 4 UPD) -> IDLE in cycle 10, round=0, busy=0, no done; a later load gives a full 22-cycle run.
REQ-042 reset asserted asynchronously mid-SUB of round 6 -> all outputs 0 before the next clock edge; after release, state remains IDLE until load.
REQ-043 abort and load both high in DONE -> IDLE, done=0, and no restart.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencing FSM (INIT, then SUB/UPD per round) driving datapath enables and rcon
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [3:0] round,
  output logic       phase,
  output logic       sel_init,
  output logic       sel_last,
  output logic       state_en,
  output logic       key_en,
  output logic [7:0] rcon
);
  typedef enum logic [2:0] {IDLE, INIT, SUB, UPD, DONE} state_t;
  state_t     st;
  logic [3:0] rnd;
  logic [7:0] rc;
  logic       last;
  // state, round counter and round constant advance; abort overrides any load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= IDLE;
      rnd <= 4'd0;
      rc  <= 8'h00;
    end else if (abort) begin
      st  <= IDLE;
      rnd <= 4'd0;
      rc  <= 8'h00;
    end else begin
      case (st)
        IDLE, DONE: if (load) begin
          st  <= INIT;
          rnd <= 4'd0;
          rc  <= 8'h00;
        end
        INIT: begin
          st  <= SUB;
          rnd <= 4'd1;
          rc  <= 8'h01;
        end
        SUB: st <= UPD;
        UPD: if (rnd == 4'(NR)) st <= DONE;
        else begin
          st  <= SUB;
          rnd <= rnd + 4'd1;
          rc  <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign last     = rnd == 4'(NR);
  assign busy     = st == INIT || st == SUB || st == UPD;
  assign done     = st == DONE;
  assign round    = rnd;
  assign phase    = st == INIT || st == UPD;
  assign sel_init = st == INIT;
  assign sel_last = (st == SUB || st == UPD) && last;
  assign state_en = st == INIT || st == UPD;
  assign key_en   = st == INIT || st == UPD;
  assign rcon     = (st == SUB || st == UPD) ? rc : 8'h00;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed checks of the AES round controller sequencing
module tb_aes_round_ctrl;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, abort = 1'b0;
  logic busy, done, phase, sel_init, sel_last, state_en, key_en;
  logic [3:0] round;
  logic [7:0] rcon;
  int vecs = 0, errs = 0, pulses;
  logic [7:0] rc_tbl [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .reset(reset), .load(load), .abort(abort), .busy(busy), .done(done),
    .round(round), .phase(phase), .sel_init(sel_init), .sel_last(sel_last),
    .state_en(state_en), .key_en(key_en), .rcon(rcon)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // expected {busy,done,phase,sel_init,sel_last,state_en,key_en,round,rcon} at cycle c after load (0 = idle)
  function automatic logic [18:0] exp_at(input int c);
    logic [6:0] o;
    logic [3:0] r;
    logic [7:0] k;
    int n;
    o = '0; r = '0; k = '0;
    if (c == 1) o = 7'b1011011;
    else if (c >= 2 && c <= 21) begin
      n = c / 2;
      r = n[3:0];
      k = rc_tbl[n];
      o = (c % 2 == 0) ? {4'b1000, n == 10, 2'b00} : {4'b1010, n == 10, 2'b11};
    end else if (c >= 22) begin
      o = 7'b0100000;
      r = 4'd10;
    end
    return {o, r, k};
  endfunction

  task automatic chk_cyc(input string tag, input int c);
    logic [18:0] e;
    e = exp_at(c);
    chk({tag, "_ctl"}, {25'd0, busy, done, phase, sel_init, sel_last, state_en, key_en}, {25'd0, e[18:12]});
    chk({tag, "_rcon"}, {24'd0, rcon}, {24'd0, e[7:0]});
    if (c < 22) chk({tag, "_round"}, {28'd0, round}, {28'd0, e[11:8]});
  endtask

  initial begin
    #1;
    chk_cyc("reset_async", 0);
    step(); step();
    chk_cyc("reset_held", 0);
    reset = 1'b0;
    step(); step();
    chk_cyc("idle_wait", 0);

    load = 1'b1;
    step();
    load = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      chk_cyc($sformatf("nom_c%0d", c), c);
      if (c <= 22) pulses += int'(state_en);
      step();
    end
    chk("se_pulses", pulses, 11);

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_cyc("abort_done", 0);

    load = 1'b1;
    step();
    for (int c = 1; c <= 30; c++) begin
      chk_cyc($sformatf("held_c%0d", c), c <= 22 ? c : c - 22);
      step();
    end
    load = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_cyc("held_abort", 0);

    load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk_cyc($sformatf("ab_c%0d", c), c);
      if (c < 9) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_cyc($sformatf("ab_idle%0d", c), 0);
      step();
    end
    load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      chk_cyc($sformatf("rerun_c%0d", c), c);
      if (c < 22) step();
    end

    abort = 1'b1;
    load = 1'b1;
    step();
    abort = 1'b0;
    load = 1'b0;
    chk_cyc("abort_load_done", 0);
    step();
    chk_cyc("abort_load_stay", 0);

    load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk_cyc($sformatf("rst_c%0d", c), c);
      if (c < 12) step();
    end
    #2 reset = 1'b1;
    #1;
    chk_cyc("rst_async_mid", 0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      chk_cyc($sformatf("rst_idle%0d", c), 0);
      step();
    end
    load = 1'b1;
    step();
    load = 1'b0;
    chk_cyc("rst_reload", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
